// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32 core: writeback select encoding, the
// decoded control bundle carried between stages and the NOP control value.
package pipeline_pkg;

  localparam int CTRL_ALU_W = 3;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_MEM  = 2'd1,
    RES_PCP4 = 2'd2,
    RES_IMM  = 2'd3
  } result_src_e;

  typedef struct packed {
    logic                  reg_write;
    result_src_e           result_src;
    logic                  mem_write;
    logic                  jump;
    logic                  branch;
    logic [CTRL_ALU_W-1:0] alu_ctrl;
    logic                  alu_src;
  } ctrl_t;

  localparam ctrl_t                 CTRL_NOP    = '0;
  localparam logic [CTRL_ALU_W-1:0] ALUCTRL_ADD = 3'b000;

  // Strip every architecturally visible side effect from a control bundle.
  function automatic ctrl_t ctrl_kill(input ctrl_t c);
    ctrl_t k;
    k           = c;
    k.reg_write = 1'b0;
    k.mem_write = 1'b0;
    k.jump      = 1'b0;
    k.branch    = 1'b0;
    return k;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_chk.sv
// Invariant checker for id_ex_pipe_reg: an invalid EX slot carries no side effects.
module id_ex_pipe_reg_chk (
  input logic clk,
  input logic Valid_E,
  input logic RegWrite_E,
  input logic MemWrite_E,
  input logic Jump_E,
  input logic Branch_E
);

  a_bubble_is_nop: assert property (@(posedge clk)
    !Valid_E |-> !(RegWrite_E || MemWrite_E || Jump_E || Branch_E))
    else $error("FAIL invariant: invalid slot with control set rw=%0b mw=%0b j=%0b b=%0b",
                RegWrite_E, MemWrite_E, Jump_E, Branch_E);

endmodule

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: rst > clr > hold (en=0) > load.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Field state with reset, bubble clear and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with stall, flush and valid tracking.
// Optional perf counters (StallCnt/BubbleCnt) enabled by ID_EX_PERF_EN.
module id_ex_pipe_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Stall_E,
  input  logic                 Flush_E,
  input  logic                 Valid_D,
  output logic                 Valid_E,
  input  logic [WIDTH-1:0]     RD1_D,
  output logic [WIDTH-1:0]     RD1_E,
  input  logic [WIDTH-1:0]     RD2_D,
  output logic [WIDTH-1:0]     RD2_E,
  input  logic [WIDTH-1:0]     PC_D,
  output logic [WIDTH-1:0]     PC_E,
  input  logic [WIDTH-1:0]     PCP4_D,
  output logic [WIDTH-1:0]     PCP4_E,
  input  logic [WIDTH-1:0]     ImmExt_D,
  output logic [WIDTH-1:0]     ImmExt_E,
  input  logic [REG_AW-1:0]    Rs1_D,
  output logic [REG_AW-1:0]    Rs1_E,
  input  logic [REG_AW-1:0]    Rs2_D,
  output logic [REG_AW-1:0]    Rs2_E,
  input  logic [REG_AW-1:0]    Rd_D,
  output logic [REG_AW-1:0]    Rd_E,
  input  logic [2:0]           Funct3_D,
  output logic [2:0]           Funct3_E,
  input  logic                 RegWrite_D,
  output logic                 RegWrite_E,
  input  logic                 MemWrite_D,
  output logic                 MemWrite_E,
  input  logic                 Jump_D,
  output logic                 Jump_E,
  input  logic                 Branch_D,
  output logic                 Branch_E,
  input  logic                 ALUsrc_D,
  output logic                 ALUsrc_E,
  input  logic [1:0]           ResultSrc_D,
  output logic [1:0]           ResultSrc_E,
  input  logic [ALUCTRL_W-1:0] ALUctrl_D,
  output logic [ALUCTRL_W-1:0] ALUctrl_E
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]     StallCnt,
  output logic [CNT_W-1:0]     BubbleCnt
`endif
);

  localparam int DATA_W = 5 * WIDTH;
  localparam int ADDR_W = 3 * REG_AW + 3;
  localparam int CTRL_W = $bits(ctrl_t);

  logic              load_en_s;
  ctrl_t             ctrl_raw_s;
  ctrl_t             ctrl_d_s;
  ctrl_t             ctrl_q_s;
  logic [DATA_W-1:0] data_q_s;
  logic [ADDR_W-1:0] addr_q_s;

  assign load_en_s = ~Stall_E;

  // Pack decoded control; an invalid slot must not carry side effects.
  always_comb begin
    ctrl_raw_s            = CTRL_NOP;
    ctrl_raw_s.reg_write  = RegWrite_D;
    ctrl_raw_s.result_src = result_src_e'(ResultSrc_D);
    ctrl_raw_s.mem_write  = MemWrite_D;
    ctrl_raw_s.jump       = Jump_D;
    ctrl_raw_s.branch     = Branch_D;
    ctrl_raw_s.alu_ctrl   = ALUctrl_D;
    ctrl_raw_s.alu_src    = ALUsrc_D;
    if (Valid_D) begin
      ctrl_d_s = ctrl_raw_s;
    end else begin
      ctrl_d_s = ctrl_kill(ctrl_raw_s);
    end
  end

  pipe_field_reg #(.W(DATA_W)) u_data (
    .clk (clk), .rst (rst), .clr (Flush_E), .en (load_en_s),
    .d   ({RD1_D, RD2_D, PC_D, PCP4_D, ImmExt_D}),
    .q   (data_q_s)
  );

  pipe_field_reg #(.W(ADDR_W)) u_addr (
    .clk (clk), .rst (rst), .clr (Flush_E), .en (load_en_s),
    .d   ({Rs1_D, Rs2_D, Rd_D, Funct3_D}),
    .q   (addr_q_s)
  );

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk), .rst (rst), .clr (Flush_E), .en (load_en_s),
    .d   (ctrl_d_s),
    .q   (ctrl_q_s)
  );

  pipe_field_reg #(.W(1)) u_valid (
    .clk (clk), .rst (rst), .clr (Flush_E), .en (load_en_s),
    .d   (Valid_D),
    .q   (Valid_E)
  );

  assign {RD1_E, RD2_E, PC_E, PCP4_E, ImmExt_E} = data_q_s;
  assign {Rs1_E, Rs2_E, Rd_E, Funct3_E}         = addr_q_s;
  assign RegWrite_E  = ctrl_q_s.reg_write;
  assign ResultSrc_E = ctrl_q_s.result_src;
  assign MemWrite_E  = ctrl_q_s.mem_write;
  assign Jump_E      = ctrl_q_s.jump;
  assign Branch_E    = ctrl_q_s.branch;
  assign ALUctrl_E   = ctrl_q_s.alu_ctrl;
  assign ALUsrc_E    = ctrl_q_s.alu_src;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic             stall_hold_s;
  logic             bubble_load_s;

  assign stall_hold_s  = Stall_E & ~Flush_E;
  assign bubble_load_s = Flush_E | (~Stall_E & ~Valid_D);

  // Saturating perf counters: held edges and bubbles entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_hold_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bubble_load_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign StallCnt  = stall_cnt_r;
  assign BubbleCnt = bubble_cnt_r;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed + randomized bench for id_ex_pipe_reg against a behavioural model.
// Define ID_EX_PERF_EN to also cover the perf counters (CNT_W=4).
module tb_id_ex_pipe_reg;
  import pipeline_pkg::*;

`ifdef ID_EX_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic clk = 1'b0;
  logic rst, Stall_E, Flush_E, Valid_D, Valid_E;
  logic [31:0] RD1_D, RD1_E, RD2_D, RD2_E, PC_D, PC_E, PCP4_D, PCP4_E, ImmExt_D, ImmExt_E;
  logic [4:0]  Rs1_D, Rs1_E, Rs2_D, Rs2_E, Rd_D, Rd_E;
  logic [2:0]  Funct3_D, Funct3_E, ALUctrl_D, ALUctrl_E;
  logic RegWrite_D, RegWrite_E, MemWrite_D, MemWrite_E, Jump_D, Jump_E;
  logic Branch_D, Branch_E, ALUsrc_D, ALUsrc_E;
  logic [1:0] ResultSrc_D, ResultSrc_E;
`ifdef ID_EX_PERF_EN
  logic [CW-1:0] StallCnt, BubbleCnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Expected EX-stage contents
  logic        m_valid, m_rw, m_mw, m_j, m_b, m_as;
  logic [31:0] m_rd1, m_rd2, m_pc, m_pcp4, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3, m_alu;
  logic [1:0]  m_res;
  longint      m_stall_cnt, m_bubble_cnt;
  longint      cnt_max;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(32), .REG_AW(5), .ALUCTRL_W(3), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Stall_E(Stall_E), .Flush_E(Flush_E),
    .Valid_D(Valid_D), .Valid_E(Valid_E),
    .RD1_D(RD1_D), .RD1_E(RD1_E), .RD2_D(RD2_D), .RD2_E(RD2_E),
    .PC_D(PC_D), .PC_E(PC_E), .PCP4_D(PCP4_D), .PCP4_E(PCP4_E),
    .ImmExt_D(ImmExt_D), .ImmExt_E(ImmExt_E),
    .Rs1_D(Rs1_D), .Rs1_E(Rs1_E), .Rs2_D(Rs2_D), .Rs2_E(Rs2_E),
    .Rd_D(Rd_D), .Rd_E(Rd_E), .Funct3_D(Funct3_D), .Funct3_E(Funct3_E),
    .RegWrite_D(RegWrite_D), .RegWrite_E(RegWrite_E),
    .MemWrite_D(MemWrite_D), .MemWrite_E(MemWrite_E),
    .Jump_D(Jump_D), .Jump_E(Jump_E), .Branch_D(Branch_D), .Branch_E(Branch_E),
    .ALUsrc_D(ALUsrc_D), .ALUsrc_E(ALUsrc_E),
    .ResultSrc_D(ResultSrc_D), .ResultSrc_E(ResultSrc_E),
    .ALUctrl_D(ALUctrl_D), .ALUctrl_E(ALUctrl_E)
`ifdef ID_EX_PERF_EN
    , .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  id_ex_pipe_reg_chk u_chk (
    .clk(clk), .Valid_E(Valid_E), .RegWrite_E(RegWrite_E),
    .MemWrite_E(MemWrite_E), .Jump_E(Jump_E), .Branch_E(Branch_E)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    {m_valid, m_rw, m_mw, m_j, m_b, m_as} = '0;
    {m_rd1, m_rd2, m_pc, m_pcp4, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_f3, m_alu, m_res} = '0;
  endtask

  // One clock edge of the stage, from the rules: reset, flush, stall, load.
  task automatic model_edge();
    if (rst) begin
      model_clear();
      m_stall_cnt = 0;
      m_bubble_cnt = 0;
    end else begin
      if (Stall_E && !Flush_E && m_stall_cnt < cnt_max) m_stall_cnt++;
      if ((Flush_E || (!Stall_E && !Valid_D)) && m_bubble_cnt < cnt_max) m_bubble_cnt++;
      if (Flush_E) begin
        model_clear();
      end else if (!Stall_E) begin
        m_valid = Valid_D;
        m_rd1 = RD1_D; m_rd2 = RD2_D; m_pc = PC_D; m_pcp4 = PCP4_D; m_imm = ImmExt_D;
        m_rs1 = Rs1_D; m_rs2 = Rs2_D; m_rd = Rd_D; m_f3 = Funct3_D;
        m_res = ResultSrc_D; m_alu = ALUctrl_D; m_as = ALUsrc_D;
        m_rw = RegWrite_D & Valid_D;
        m_mw = MemWrite_D & Valid_D;
        m_j  = Jump_D & Valid_D;
        m_b  = Branch_D & Valid_D;
      end
    end
  endtask

  task automatic check_all();
    check("Valid_E", Valid_E, m_valid);
    check("RD1_E", RD1_E, m_rd1);
    check("RD2_E", RD2_E, m_rd2);
    check("PC_E", PC_E, m_pc);
    check("PCP4_E", PCP4_E, m_pcp4);
    check("ImmExt_E", ImmExt_E, m_imm);
    check("Rs1_E", Rs1_E, m_rs1);
    check("Rs2_E", Rs2_E, m_rs2);
    check("Rd_E", Rd_E, m_rd);
    check("Funct3_E", Funct3_E, m_f3);
    check("RegWrite_E", RegWrite_E, m_rw);
    check("MemWrite_E", MemWrite_E, m_mw);
    check("Jump_E", Jump_E, m_j);
    check("Branch_E", Branch_E, m_b);
    check("ALUsrc_E", ALUsrc_E, m_as);
    check("ResultSrc_E", ResultSrc_E, m_res);
    check("ALUctrl_E", ALUctrl_E, m_alu);
`ifdef ID_EX_PERF_EN
    check("StallCnt", StallCnt, m_stall_cnt);
    check("BubbleCnt", BubbleCnt, m_bubble_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_d(input logic force_nonzero);
    RD1_D = $urandom(); RD2_D = $urandom(); PC_D = $urandom();
    PCP4_D = $urandom(); ImmExt_D = $urandom();
    Rs1_D = 5'($urandom()); Rs2_D = 5'($urandom()); Rd_D = 5'($urandom());
    Funct3_D = 3'($urandom()); ALUctrl_D = 3'($urandom()); ResultSrc_D = 2'($urandom());
    {RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUsrc_D} = 5'($urandom());
    Valid_D = 1'($urandom());
    if (force_nonzero) begin
      RD1_D[0] = 1'b1; RD2_D[0] = 1'b1; PC_D[0] = 1'b1; PCP4_D[0] = 1'b1; ImmExt_D[0] = 1'b1;
      Rs1_D[0] = 1'b1; Rs2_D[0] = 1'b1; Rd_D[0] = 1'b1; Funct3_D[0] = 1'b1;
      ALUctrl_D[0] = 1'b1; ResultSrc_D[0] = 1'b1;
      {RegWrite_D, MemWrite_D, Jump_D, Branch_D, ALUsrc_D, Valid_D} = 6'b111111;
    end
  endtask

  initial begin
    cnt_max = (longint'(1) << CW) - 1;
    m_stall_cnt = 0;
    m_bubble_cnt = 0;
    model_clear();
    Stall_E = 1'b0; Flush_E = 1'b0; rst = 1'b1;
    rand_d(1'b1);

    // Reset held two edges with every input nonzero
    tick();
    tick();
    check("rst_valid", Valid_E, 1'b0);
    check("rst_pc", PC_E, 32'h0);
    check("rst_regwrite", RegWrite_E, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_rd2", RD2_E, RD2_D);
    check("post_rst_valid", Valid_E, 1'b1);

    // Plain load
    RD1_D = 32'hDEAD_BEEF; Rd_D = 5'd7; RegWrite_D = 1'b1; Valid_D = 1'b1;
    tick();
    check("load_rd1", RD1_E, 32'hDEAD_BEEF);
    check("load_rd", Rd_E, 5'd7);
    check("load_regwrite", RegWrite_E, 1'b1);
    check("load_valid", Valid_E, 1'b1);

    // Stall holds for three edges, release loads the new PC
    PC_D = 32'h100;
    tick();
    PC_D = 32'h104; Stall_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", PC_E, 32'h100);
    end
    Stall_E = 1'b0;
    tick();
    check("release_pc", PC_E, 32'h104);

    // Flush wins over stall
    Stall_E = 1'b1; Flush_E = 1'b1; MemWrite_D = 1'b1; Valid_D = 1'b1;
    tick();
    check("flush_valid", Valid_E, 1'b0);
    check("flush_memwrite", MemWrite_E, 1'b0);
    check("flush_pc", PC_E, 32'h0);
    Stall_E = 1'b0; Flush_E = 1'b0;

    // Invalid slot loads with control killed but data as-is
    Valid_D = 1'b0; Branch_D = 1'b1; Jump_D = 1'b1; ImmExt_D = 32'h0000_0ABC;
    tick();
    check("inv_branch", Branch_E, 1'b0);
    check("inv_jump", Jump_E, 1'b0);
    check("inv_valid", Valid_E, 1'b0);
    check("inv_imm", ImmExt_E, 32'h0000_0ABC);

    // Reset during stall, then a normal load
    rand_d(1'b1);
    tick();
    Stall_E = 1'b1; rst = 1'b1;
    tick();
    check("rst_stall_valid", Valid_E, 1'b0);
    rst = 1'b0; Stall_E = 1'b0;
    tick();
    check("rst_stall_reload", Valid_E, 1'b1);

`ifdef ID_EX_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; Stall_E = 1'b1; Valid_D = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("stallcnt_sat", StallCnt, 4'hF);
    Stall_E = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; Flush_E = 1'b1;
    tick();
    tick();
    check("bubblecnt_two", BubbleCnt, 4'd2);
    Flush_E = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_d(1'b0);
      Stall_E = ($urandom_range(0, 3) == 0);
      Flush_E = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
